// File: rtl/gcr62_stream_encoder.sv
// Streaming 6:2 GCR nibbler: groups of up to three payload bytes in, four disk bytes out,
// then a 4-byte rolling checksum. Define GCR62_XLAT_EN to map 6-bit values to disk bytes.
module gcr62_stream_encoder #(
  parameter int unsigned LEN_W = 11
) (
  input  logic             clk,
  input  logic             nibbler_reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    StIdle, StFill, StHi, StN0, StN1, StN2, StSum0, StSum1, StSum2, StSum3
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [7:0]       c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic             c2x_q, c2x_d, c3x_q, c3x_d;
  logic [7:0]       x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic             done_q, done_d;

  logic [7:0] c1_rot;
  logic [8:0] sum3, sum2;
  logic [7:0] sum1;
  logic [5:0] v6;
  state_e     grp_next;

`ifdef GCR62_XLAT_EN
  function automatic logic [7:0] xlat(input logic [5:0] v);
    logic [7:0] r;
    unique case (v)
      6'h00: r = 8'h96;  6'h01: r = 8'h97;  6'h02: r = 8'h9A;  6'h03: r = 8'h9B;
      6'h04: r = 8'h9D;  6'h05: r = 8'h9E;  6'h06: r = 8'h9F;  6'h07: r = 8'hA6;
      6'h08: r = 8'hA7;  6'h09: r = 8'hAB;  6'h0A: r = 8'hAC;  6'h0B: r = 8'hAD;
      6'h0C: r = 8'hAE;  6'h0D: r = 8'hAF;  6'h0E: r = 8'hB2;  6'h0F: r = 8'hB3;
      6'h10: r = 8'hB4;  6'h11: r = 8'hB5;  6'h12: r = 8'hB6;  6'h13: r = 8'hB7;
      6'h14: r = 8'hB9;  6'h15: r = 8'hBA;  6'h16: r = 8'hBB;  6'h17: r = 8'hBC;
      6'h18: r = 8'hBD;  6'h19: r = 8'hBE;  6'h1A: r = 8'hBF;  6'h1B: r = 8'hCB;
      6'h1C: r = 8'hCD;  6'h1D: r = 8'hCE;  6'h1E: r = 8'hCF;  6'h1F: r = 8'hD3;
      6'h20: r = 8'hD6;  6'h21: r = 8'hD7;  6'h22: r = 8'hD9;  6'h23: r = 8'hDA;
      6'h24: r = 8'hDB;  6'h25: r = 8'hDC;  6'h26: r = 8'hDD;  6'h27: r = 8'hDE;
      6'h28: r = 8'hDF;  6'h29: r = 8'hE5;  6'h2A: r = 8'hE6;  6'h2B: r = 8'hE7;
      6'h2C: r = 8'hE9;  6'h2D: r = 8'hEA;  6'h2E: r = 8'hEB;  6'h2F: r = 8'hEC;
      6'h30: r = 8'hED;  6'h31: r = 8'hEE;  6'h32: r = 8'hEF;  6'h33: r = 8'hF2;
      6'h34: r = 8'hF3;  6'h35: r = 8'hF4;  6'h36: r = 8'hF5;  6'h37: r = 8'hF6;
      6'h38: r = 8'hF7;  6'h39: r = 8'hF9;  6'h3A: r = 8'hFA;  6'h3B: r = 8'hFB;
      6'h3C: r = 8'hFC;  6'h3D: r = 8'hFD;  6'h3E: r = 8'hFE;  default: r = 8'hFF;
    endcase
    return r;
  endfunction
`endif

  assign c1_rot   = {c1_q[6:0], c1_q[7]};
  assign sum3     = {1'b0, c3_q} + {1'b0, in_data} + {8'd0, c1_q[7]};
  assign sum2     = {1'b0, c2_q} + {1'b0, in_data} + {8'd0, c3x_q};
  assign sum1     = c1_q + in_data + {7'd0, c2x_q};
  assign grp_next = (remaining_q != '0) ? StFill : StSum0;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    c1_d        = c1_q;
    c2_d        = c2_q;
    c3_d        = c3_q;
    c2x_d       = c2x_q;
    c3x_d       = c3x_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    v6          = 6'd0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = len;
          cnt_d       = 2'd0;
          c1_d        = 8'd0;
          c2_d        = 8'd0;
          c3_d        = 8'd0;
          c2x_d       = 1'b0;
          c3x_d       = 1'b0;
          state_d     = (len == '0) ? StSum0 : StFill;
        end
      end
      StFill: begin
        in_ready = 1'b1;
        if (in_valid) begin
          remaining_d = remaining_q - LEN_W'(1);
          cnt_d       = cnt_q + 2'd1;
          unique case (cnt_q)
            2'd0: begin
              c1_d          = c1_rot;
              {c3x_d, c3_d} = sum3;
              x0_d          = in_data ^ c1_rot;
              x1_d          = 8'd0;
              x2_d          = 8'd0;
            end
            2'd1: begin
              {c2x_d, c2_d} = sum2;
              c3x_d         = 1'b0;
              x1_d          = in_data ^ c3_q;
            end
            default: begin
              c1_d  = sum1;
              c2x_d = 1'b0;
              x2_d  = in_data ^ c2_q;
            end
          endcase
          if (cnt_q == 2'd2 || remaining_q == LEN_W'(1)) state_d = StHi;
        end
      end
      StHi: begin
        out_valid = 1'b1;
        v6        = {x0_q[7:6], x1_q[7:6], x2_q[7:6]};
        if (out_ready) state_d = StN0;
      end
      StN0: begin
        out_valid = 1'b1;
        v6        = x0_q[5:0];
        if (out_ready) state_d = (cnt_q == 2'd1) ? grp_next : StN1;
      end
      StN1: begin
        out_valid = 1'b1;
        v6        = x1_q[5:0];
        if (out_ready) state_d = (cnt_q == 2'd2) ? grp_next : StN2;
      end
      StN2: begin
        out_valid = 1'b1;
        v6        = x2_q[5:0];
        if (out_ready) state_d = grp_next;
      end
      StSum0: begin
        out_valid = 1'b1;
        v6        = {c3_q[7:6], c2_q[7:6], c1_q[7:6]};
        if (out_ready) state_d = StSum1;
      end
      StSum1: begin
        out_valid = 1'b1;
        v6        = c3_q[5:0];
        if (out_ready) state_d = StSum2;
      end
      StSum2: begin
        out_valid = 1'b1;
        v6        = c2_q[5:0];
        if (out_ready) state_d = StSum3;
      end
      StSum3: begin
        out_valid = 1'b1;
        v6        = c1_q[5:0];
        if (out_ready) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Group counter restarts whenever the nibble phase of a group ends.
    if (out_valid && out_ready && (state_d == StFill || state_d == StSum0)) cnt_d = 2'd0;
  end

  always_ff @(posedge clk or posedge nibbler_reset) begin
    if (nibbler_reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cnt_q       <= 2'd0;
      c1_q        <= 8'd0;
      c2_q        <= 8'd0;
      c3_q        <= 8'd0;
      c2x_q       <= 1'b0;
      c3x_q       <= 1'b0;
      x0_q        <= 8'd0;
      x1_q        <= 8'd0;
      x2_q        <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      c3_q        <= c3_d;
      c2x_q       <= c2x_d;
      c3x_q       <= c3x_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      done_q      <= done_d;
    end
  end

`ifdef GCR62_XLAT_EN
  assign out_data = out_valid ? xlat(v6) : 8'h00;
`else
  assign out_data = out_valid ? {2'b00, v6} : 8'h00;
`endif

  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: doc/gcr62_stream_encoder.md
Name: gcr62_stream_encoder

Overview:
- Streaming Sony/Apple 6:2 "nibbler" for GCR floppy tracks.
- Consumes a variable-length run of raw sector bytes (512 data, 524 tag+data, or any length up to MAX_LEN) over a valid/ready handshake.
- Produces the 6:2-encoded disk-byte stream, followed by the 4-byte rolling checksum.
- Sits between the sector RAM fetch path and the track serializer. Replaces fixed-512, free-running nibbling with a backpressured, length-programmable engine.

Parameters:
- LEN_W, 11, width of len port; MAX_LEN = 2**LEN_W-1 bytes.

Ports:
- clk  in  1  clock
- nibbler_reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begin a block (ignored while busy)
- len  in  LEN_W  payload byte count, sampled on accepted start
- in_data  in  8  raw payload byte
- in_valid  in  1  in_data valid
- in_ready  out  1  encoder accepts byte this cycle
- out_data  out  8  encoded byte (see Optional Feature)
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  block in progress
- done  out  1  one-cycle pulse after last checksum byte accepted

Behaviour:
- Reset (async, nibbler_reset=1):
  - state=IDLE; c1=c2=c3=0; c2x=c3x=0; remaining=0.
  - in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- Transfer rules:
  - Input transfer occurs on in_valid&&in_ready.
  - Output transfer occurs on out_valid&&out_ready.
  - While out_valid=1, out_data stays stable until transferred.
- States and transitions:
  - IDLE: on start, latch len into remaining, clear checksums/carries, set busy=1. If len=0 go to SUM0, else go to FILL.
  - FILL: in_ready=1. Accept k=min(3,remaining) bytes b0..b(k-1), any number of cycles apart. Per accepted byte:
    - b0: c1<=rotl1(c1); {c3x,c3}<=c3+b0+old c1[7]; x0<=b0^rotl1(c1).
    - b1: {c2x,c2}<=c2+b1+c3x; c3x<=0; x1<=b1^new c3.
    - b2: c1<=c1+b2+c2x (8-bit wrap); c2x<=0; x2<=b2^new c2.
    - Unreceived x registers are 0. Decrement remaining per byte.
    - After the k-th byte, in_ready drops the next cycle and the state goes to HI.
  - HI: emit {x0[7:6],x1[7:6],x2[7:6]}. Then N0..N(k-1) emit x0[5:0], x1[5:0], x2[5:0] respectively.
  - After the last nibble of the group: if remaining>0 go to FILL, else go to SUM0.
  - SUM0..SUM3: emit {c3[7:6],c2[7:6],c1[7:6]}, c3[5:0], c2[5:0], c1[5:0].
  - After SUM3 transfers: done=1 for one cycle, busy=0, state=IDLE.
- Output count: 4*floor(len/3) + (len%3 ? len%3+1 : 0) + 4. Examples: len=512 gives 683+4; len=524 gives 699+4.
- Partial last group: missing bytes are not requested and do not update any checksum. Pending c2x/c3x carries are discarded.
- Latency:
  - First output byte has out_valid=1 one cycle after the group's final input transfer.
  - Each subsequent output advances one cycle after its predecessor transfers.
  - With in_valid and out_ready held high, a 3-byte group costs 3 input cycles plus 4 output cycles.
- Boundary cases:
  - start during busy: ignored.
  - in_valid outside FILL: ignored, no consumption.
  - Reset mid-block: immediate IDLE. No done pulse, partial output discarded.
  - len>MAX_LEN: impossible by width.

Optional Feature:
- Macro: GCR62_XLAT_EN.
- Defined: each 6-bit value v is translated through the Sony 64-entry disk-byte table before driving out_data (0x00->0x96, 0x01->0x97, 0x02->0x9A, 0x03->0x9B, ..., 0x30->0xED, ..., 0x3F->0xFF).
- Undefined: out_data = {2'b00, v}. The table is not synthesized.
- Handshake and timing are identical in both builds.

Test Plan:
- XLAT on, len=3, bytes 00 00 00 -> out 96 96 96 96 | 96 96 96 96; done pulses once; total 8 bytes.
- XLAT on, len=1, byte FF -> out ED FF | ED FF 96 96. XLAT off, same stimulus -> 30 3F 30 3F 00 00.
- XLAT on, len=2, bytes 01 02 -> out 96 97 9B | 96 97 9A 96; in_ready never requests a third byte.
- XLAT on, len=4, bytes FF FF FF FF (exercises rotl carry and c3x) -> ED FF 96 96 96 96 | FF FF FF FF.
- len=512, random data, random in_valid/out_ready stalls -> exactly 687 outputs. Byte stream and checksum match the software model; out_data stays stable across every stall.
- Reset asserted at output 100 of a 512-byte block -> busy=0, out_valid=0, in_ready=0 immediately. A following start with len=3 (bytes 00 00 00) reproduces the first scenario exactly.
